// File: rtl/multiplicador_booth.sv
// Sequential radix-2 Booth multiplier: full 2*WIDTH-bit product, signed or unsigned per operation.
// Operands are extended to WIDTH+1 bits so that one datapath serves both modes.
//
// state | meaning
// IDLE  | waiting for start; product registers hold the last result
// RUN   | one Booth step per cycle, WIDTH+1 steps in total
module multiplicador_booth #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] fator_1,
  input  logic [WIDTH-1:0] fator_2,
  output logic [WIDTH-1:0] msb_prod,
  output logic [WIDTH-1:0] lsb_prod,
  output logic             calculando,
  output logic             pronto
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   q_q, q_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] msb_q, msb_d;
  logic [WIDTH-1:0] lsb_q, lsb_d;
  logic             pronto_q, pronto_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   q_sh;

  always_comb begin
    unique case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q + ~m_q + ONE;
      default: sum = a_q;
    endcase
    a_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh = {sum[0], q_q[WIDTH:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    msb_d    = msb_q;
    lsb_d    = lsb_q;
    pronto_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {is_signed & fator_1[WIDTH-1], fator_1};
          q_d     = {is_signed & fator_2[WIDTH-1], fator_2};
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q + CW'(1);
        // Last step: the low 2*WIDTH bits of the shifted {A,Q} are the exact product.
        if (cnt_q == CW'(WIDTH)) begin
          msb_d    = {a_sh[WIDTH-2:0], q_sh[WIDTH]};
          lsb_d    = q_sh[WIDTH-1:0];
          pronto_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      msb_q    <= '0;
      lsb_q    <= '0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      msb_q    <= msb_d;
      lsb_q    <= lsb_d;
      pronto_q <= pronto_d;
    end
  end

  assign msb_prod   = msb_q;
  assign lsb_prod   = lsb_q;
  assign pronto     = pronto_q;
  assign calculando = (state_q == RUN);

endmodule

// File: tb/tb_multiplicador_booth.sv
// Bench for multiplicador_booth at WIDTH=32 (directed cases, handshake, reset abort)
// and WIDTH=8 (corner grid plus random pairs in both modes) against a widened-multiply model.
`timescale 1ns/1ps
module tb_multiplicador_booth;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        start32, sgn32;
  logic [31:0] f1_32, f2_32, msb32, lsb32;
  logic        calc32, pronto32;

  logic        start8, sgn8;
  logic [7:0]  f1_8, f2_8, msb8, lsb8;
  logic        calc8, pronto8;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiplicador_booth #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .is_signed(sgn32),
    .fator_1(f1_32), .fator_2(f2_32), .msb_prod(msb32), .lsb_prod(lsb32),
    .calculando(calc32), .pronto(pronto32)
  );

  multiplicador_booth #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .is_signed(sgn8),
    .fator_1(f1_8), .fator_2(f2_8), .msb_prod(msb8), .lsb_prod(lsb8),
    .calculando(calc8), .pronto(pronto8)
  );

  function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    @(negedge clk);
    sgn32 = s; f1_32 = a; f2_32 = b; start32 = 1'b1;
    sb32.push_back(e);
    @(posedge clk); #1;
    start32 = 1'b0;
    chk("calc32_after_start", calc32, 1);
  endtask

  task automatic wait_op32(input string tag);
    int lat;
    logic done;
    logic [63:0] e;
    lat = 0; done = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (pronto32) done = 1'b1;
    end
    chk({tag, "_pronto_seen"}, done, 1);
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_calc_low_at_pronto"}, calc32, 0);
    e = (sb32.size() > 0) ? sb32.pop_front() : 64'hx;
    chk({tag, "_product"}, {msb32, lsb32}, e);
  endtask

  task automatic op32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    start_op32(s, a, b, e);
    wait_op32(tag);
    @(posedge clk); #1;
    chk({tag, "_pronto_one_cycle"}, pronto32, 0);
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic done;
    logic [15:0] e;
    @(negedge clk);
    sgn8 = s; f1_8 = a; f2_8 = b; start8 = 1'b1;
    sb8.push_back(model8(s, a, b));
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; done = 1'b0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (pronto8) done = 1'b1;
    end
    chk("w8_pronto_seen", done, 1);
    chk("w8_latency", lat, 9);
    e = (sb8.size() > 0) ? sb8.pop_front() : 16'hx;
    chk($sformatf("w8_s%0d_%0h_x_%0h", s, a, b), {msb8, lsb8}, e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n_pr;
    logic done;
    logic [63:0] e;
    logic [31:0] r;
    logic [7:0] cor[6];
    cor = '{8'h00, 8'h01, 8'h02, 8'h7f, 8'h80, 8'hff};

    reset_n = 1'b0;
    start32 = 0; sgn32 = 0; f1_32 = 0; f2_32 = 0;
    start8 = 0; sgn8 = 0; f1_8 = 0; f2_8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prod32", {msb32, lsb32}, 0);
    chk("rst_calc32", calc32, 0);
    chk("rst_pronto32", pronto32, 0);
    chk("rst_prod8", {msb8, lsb8}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed WIDTH=32 cases
    op32("neg7x3",       1, 32'hFFFFFFF9, 32'd3,        64'hFFFFFFFF_FFFFFFEB);
    op32("ffxff_uns",    0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    op32("ffxff_sgn",    1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    op32("minxmin",      1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    op32("maxxmin",      1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      op32("rand32", i[0], a, b, model32(i[0], a, b));
    end

    // Handshake: start pulses during RUN must be ignored
    start_op32(0, 32'd5, 32'd6, 64'd30);
    lat = 0; done = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start32 = (lat == 3 || lat == 10 || lat == 20);
      f1_32 = 32'hDEAD_0000; f2_32 = lat;
      if (pronto32) done = 1'b1;
    end
    start32 = 1'b0;
    chk("hs1_pronto_seen", done, 1);
    chk("hs1_latency", lat, 33);
    e = (sb32.size() > 0) ? sb32.pop_front() : 64'hx;
    chk("hs1_product", {msb32, lsb32}, e);

    // New start inside the pronto cycle
    sgn32 = 0; f1_32 = 32'd2; f2_32 = 32'd3; start32 = 1'b1;
    sb32.push_back(64'd6);
    @(posedge clk); #1;
    start32 = 1'b0;
    chk("hs2_pronto_drops", pronto32, 0);
    chk("hs2_calc_high", calc32, 1);
    lat = 0; done = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (pronto32) done = 1'b1;
      else chk("hs2_hold_prev", {msb32, lsb32}, 64'd30);
    end
    chk("hs2_pronto_seen", done, 1);
    chk("hs2_latency", lat, 33);
    e = (sb32.size() > 0) ? sb32.pop_front() : 64'hx;
    chk("hs2_product", {msb32, lsb32}, e);

    // Reset in the middle of an operation
    @(negedge clk);
    sgn32 = 1; f1_32 = 32'd100; f2_32 = 32'hFFFFFFFD; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_prod", {msb32, lsb32}, 0);
    chk("abort_calc", calc32, 0);
    chk("abort_pronto", pronto32, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n_pr = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pronto32) n_pr++;
    end
    chk("abort_no_pronto", n_pr, 0);
    op32("after_abort", 1, 32'hFFFFFFF7, 32'd11, model32(1, 32'hFFFFFFF7, 32'd11));

    // WIDTH=8: corner grid then random pairs in both modes
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          op8(s[0], cor[i], cor[j]);
    for (int k = 0; k < 2400; k++) begin
      r = $urandom;
      op8(k[0], r[7:0], r[15:8]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
